scan_display_driver: RTL and testbench
======================================

// Module: scan_display_driver
// PURPOSE
//   Consumer end of the clock counter's digit interface. Takes six BCD digits
//   (HH:MM:SS) and drives a 6-digit common-anode multiplexed 7-segment display.
//   Each frame starts with a validated snapshot, so transient carry values
//   (digit = 10, seconds2 = 6, ...) never reach the display.
//   The block also applies per-slot guard blanking to suppress ghosting.
// PARAMETERS
//   SCAN_DIV  50_000  clock cycles per digit slot (1 ms at 50 MHz); must be >= 2
//   GUARD     500     cycles at slot start with all SEL off; must be < SCAN_DIV
// PORTS
//   CLK_50M        in   1  system clock, 50 MHz
//   RST            in   1  asynchronous, active-high reset
//   hours2_data    in   4  hours tens, BCD
//   hours1_data    in   4  hours units, BCD
//   minutes2_data  in   4  minutes tens, BCD
//   minutes1_data  in   4  minutes units, BCD
//   seconds2_data  in   4  seconds tens, BCD
//   seconds1_data  in   4  seconds units, BCD
//   blank_lz       in   1  1 = blank hours tens digit when it is 0
//   dot_en         in   1  1 = light decimal points after hours/minutes units
//   SEG            out  8  {dp,g,f,e,d,c,b,a}, active-low
//   SEL            out  6  digit enables, active-low; SEL[5] = hours tens (left)
//   frame_start    out  1  one-cycle pulse when the snapshot is taken
// BEHAVIOUR
//   - Reset (async):
//       div_cnt = 0, slot = 0, SEG = 8'hFF, SEL = 6'h3F, frame_start = 0.
//       Snapshot resets to 12:00:00, matching the counter's reset time.
//   - Prescaler div_cnt counts 0..SCAN_DIV-1 and wraps.
//     tick = (div_cnt == SCAN_DIV-1).
//   - Slot counter slot counts 0..5. On tick it increments; on tick with slot == 5
//     it wraps to 0.
//     Slot map: 0 = s1, 1 = s2, 2 = m1, 3 = m2, 4 = h1, 5 = h2.
//   - Snapshot is evaluated on the wrap tick (slot 5 -> 0) and on the first
//     cycle after reset release.
//     * Inputs are sampled in that cycle.
//     * Load only if all hold: every digit <= 9, seconds2 <= 5, minutes2 <= 5,
//       hours2 <= 2, and (hours2 != 2 || hours1 <= 3).
//     * Otherwise keep the previous snapshot; the rejected set is never
//       partially loaded.
//     * frame_start pulses in the evaluation cycle whether or not the load
//       happens.
//   - SEG and SEL are registered, with one cycle latency from div_cnt/slot to pins.
//     * While div_cnt < GUARD: SEL = 6'h3F, SEG = 8'hFF.
//     * Otherwise: SEL = ~(6'b1 << slot), SEG = decode(snapshot[slot]).
//   - Decode table, {g..a} active-low:
//       0:C0  1:F9  2:A4  3:B0  4:99  5:92  6:82  7:F8  8:80  9:90
//     dp (bit 7) is 0 only when dot_en = 1 and slot is 2 or 4; otherwise 1.
//   - Leading-zero blanking: when blank_lz = 1, slot = 5 and snapshot h2 = 0,
//     SEG = 8'hFF while SEL[5] is still asserted.
//   - Input changes mid-frame have no effect until the next snapshot.
//   - Reset mid-frame: outputs go dark at once; the scan restarts at slot 0
//     with the reset snapshot.
//   - Refresh rate = 50e6 / (6 * SCAN_DIV) ≈ 167 Hz at default settings.
// TESTING  (SCAN_DIV = 8, GUARD = 2)
//   1. Assert RST mid-cycle
//        -> SEL = 3F, SEG = FF immediately.
//      Release RST
//        -> frame_start pulses; slot 0 shows "0" (SEG = C0, SEL = 3E) after the
//           guard; hold until div_cnt wraps.
//   2. Apply 12:34:56, wait one frame
//        -> slot 0: SEG = 82, SEL = 3E
//        -> slot 3: SEG = B0, SEL = 37
//        -> slot 5: SEG = F9, SEL = 1F
//        -> SEL = 3F for exactly 2 cycles at each slot start.
//   3. Drive seconds1 = 10 only in the wrap-tick cycle (display showing 12:34:56)
//        -> frame_start = 1, snapshot unchanged; next frame still shows 12:34:56.
//   4. blank_lz = 1, apply 09:00:00
//        -> slot 5: SEG = FF, SEL = 1F; slot 4: SEG = 90.
//      blank_lz = 0
//        -> slot 5: SEG = C0.
//   5. dot_en = 1 with 12:34:56
//        -> slot 2: SEG = 19 (4 with dp); slot 4: SEG = 24 (2 with dp);
//           slot 0 dp stays 1 (SEG = 82).
//   6. Apply 23:59:59 then 24:00:00 at a wrap
//        -> 24 is rejected, display holds 23:59:59.
//      Apply 00:00:00
//        -> accepted at the next frame.

Source files
------------

// File: rtl/scan_display_driver_if.sv
// Digit interface between the clock counter (master) and the scanned display driver (slave).
// Carries the six BCD digits and display options in, and the multiplexed pin drive out.
interface scan_display_driver_if;
  logic [3:0] hours2_data;
  logic [3:0] hours1_data;
  logic [3:0] minutes2_data;
  logic [3:0] minutes1_data;
  logic [3:0] seconds2_data;
  logic [3:0] seconds1_data;
  logic       blank_lz;
  logic       dot_en;
  logic [7:0] SEG;
  logic [5:0] SEL;
  logic       frame_start;

  modport master (
    output hours2_data, hours1_data, minutes2_data, minutes1_data,
           seconds2_data, seconds1_data, blank_lz, dot_en,
    input  SEG, SEL, frame_start
  );

  modport slave (
    input  hours2_data, hours1_data, minutes2_data, minutes1_data,
           seconds2_data, seconds1_data, blank_lz, dot_en,
    output SEG, SEL, frame_start
  );
endinterface

// File: rtl/scan_display_driver.sv
// Six-digit common-anode multiplexed 7-segment driver for an HH:MM:SS clock.
// A validated snapshot is taken once per frame so carry transients never reach the display.
module scan_display_driver #(
  parameter int SCAN_DIV = 50_000,
  parameter int GUARD    = 500
) (
  input  logic                 CLK_50M,
  input  logic                 RST,
  scan_display_driver_if.slave disp
);

  localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  logic [DW-1:0]   div_cnt;
  logic [2:0]      slot;
  logic [2:0]      slot_next;
  logic            started;
  logic            tick;
  logic            wrap;
  logic            eval;
  logic            valid;
  logic [5:0][3:0] cur;
  logic [5:0][3:0] snap;
  logic [3:0]      digit;
  logic [6:0]      glyph;
  logic            dp;
  logic [7:0]      seg_next;
  logic [5:0]      sel_next;

  // Index order matches the slot map: 0 = s1 ... 5 = h2.
  assign cur = {disp.hours2_data, disp.hours1_data, disp.minutes2_data,
                disp.minutes1_data, disp.seconds2_data, disp.seconds1_data};

  assign tick = (div_cnt == DW'(SCAN_DIV - 1));
  assign wrap = tick && (slot == 3'd5);
  assign eval = !started || wrap;
  assign disp.frame_start = eval && !RST;

  always_ff @(posedge CLK_50M or posedge RST) begin
    if (RST) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // started stays low for exactly the first cycle after reset release.
  always_ff @(posedge CLK_50M or posedge RST) begin
    if (RST) begin
      started <= 1'b0;
    end else begin
      started <= 1'b1;
    end
  end

  // Slot sequencer: state register, next-state logic, output logic.
  always_ff @(posedge CLK_50M or posedge RST) begin
    if (RST) begin
      slot <= 3'd0;
    end else begin
      slot <= slot_next;
    end
  end

  always_comb begin
    slot_next = slot;
    if (tick) begin
      slot_next = wrap ? 3'd0 : slot + 3'd1;
    end
  end

  always_comb begin
    valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (cur[i] > 4'd9) valid = 1'b0;
    end
    if (cur[1] > 4'd5) valid = 1'b0;
    if (cur[3] > 4'd5) valid = 1'b0;
    if (cur[5] > 4'd2) valid = 1'b0;
    if ((cur[5] == 4'd2) && (cur[4] > 4'd3)) valid = 1'b0;
  end

  // A rejected digit set leaves the whole previous snapshot in place.
  always_ff @(posedge CLK_50M or posedge RST) begin
    if (RST) begin
      snap <= {4'd1, 4'd2, 4'd0, 4'd0, 4'd0, 4'd0};
    end else if (eval && valid) begin
      snap <= cur;
    end
  end

  always_comb begin
    digit = 4'd0;
    case (slot)
      3'd0:    digit = snap[0];
      3'd1:    digit = snap[1];
      3'd2:    digit = snap[2];
      3'd3:    digit = snap[3];
      3'd4:    digit = snap[4];
      3'd5:    digit = snap[5];
      default: digit = 4'd0;
    endcase
  end

  always_comb begin
    glyph = 7'h7F;
    case (digit)
      4'd0:    glyph = 7'h40;
      4'd1:    glyph = 7'h79;
      4'd2:    glyph = 7'h24;
      4'd3:    glyph = 7'h30;
      4'd4:    glyph = 7'h19;
      4'd5:    glyph = 7'h12;
      4'd6:    glyph = 7'h02;
      4'd7:    glyph = 7'h78;
      4'd8:    glyph = 7'h00;
      4'd9:    glyph = 7'h10;
      default: glyph = 7'h7F;
    endcase
  end

  assign dp = !(disp.dot_en && ((slot == 3'd2) || (slot == 3'd4)));

  // Guard window keeps all anodes off while the segment lines settle.
  always_comb begin
    seg_next = 8'hFF;
    sel_next = 6'h3F;
    if (div_cnt >= DW'(GUARD)) begin
      sel_next = ~(6'b000001 << slot);
      seg_next = {dp, glyph};
      if (disp.blank_lz && (slot == 3'd5) && (digit == 4'd0)) begin
        seg_next = 8'hFF;
      end
    end
  end

  always_ff @(posedge CLK_50M or posedge RST) begin
    if (RST) begin
      disp.SEG <= 8'hFF;
      disp.SEL <= 6'h3F;
    end else begin
      disp.SEG <= seg_next;
      disp.SEL <= sel_next;
    end
  end

endmodule

// File: tb/tb_scan_display_driver.sv
// Directed bench for scan_display_driver with SCAN_DIV = 8, GUARD = 2.
// Expected slot images are queued when digits are applied and popped as each slot lights.
module tb_scan_display_driver;

  typedef struct packed {
    logic [7:0] seg;
    logic [5:0] sel;
  } slot_exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  slot_exp_t  exp_q[$];
  logic [3:0] msnap[6];
  logic [6:0] seg_tbl[10];
  logic [5:0] sel_tbl[6];

  scan_display_driver_if bus();

  scan_display_driver #(.SCAN_DIV(8), .GUARD(2)) dut (
    .CLK_50M(clk),
    .RST    (rst),
    .disp   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic [3:0] h2, h1, m2, m1, s2, s1);
    bus.hours2_data   = h2;
    bus.hours1_data   = h1;
    bus.minutes2_data = m2;
    bus.minutes1_data = m1;
    bus.seconds2_data = s2;
    bus.seconds1_data = s1;
  endtask

  task automatic model_reset();
    msnap[0] = 0; msnap[1] = 0; msnap[2] = 0;
    msnap[3] = 0; msnap[4] = 2; msnap[5] = 1;
  endtask

  task automatic model_apply(input logic [3:0] h2, h1, m2, m1, s2, s1);
    bit ok;
    ok = (h2 <= 2) && (h1 <= 9) && (m2 <= 5) && (m1 <= 9) && (s2 <= 5) && (s1 <= 9)
         && !(h2 == 2 && h1 > 3);
    if (ok) begin
      msnap[0] = s1; msnap[1] = s2; msnap[2] = m1;
      msnap[3] = m2; msnap[4] = h1; msnap[5] = h2;
    end
  endtask

  task automatic push_expected();
    slot_exp_t e;
    logic      dpv;
    for (int s = 0; s < 6; s++) begin
      dpv   = !(bus.dot_en && (s == 2 || s == 4));
      e.seg = {dpv, seg_tbl[msnap[s]]};
      if (bus.blank_lz && s == 5 && msnap[5] == 0) e.seg = 8'hFF;
      e.sel = sel_tbl[s];
      exp_q.push_back(e);
    end
  endtask

  task automatic apply(input logic [3:0] h2, h1, m2, m1, s2, s1);
    drive(h2, h1, m2, m1, s2, s1);
    model_apply(h2, h1, m2, m1, s2, s1);
    push_expected();
  endtask

  task automatic wait_fs();
    bit seen;
    seen = 0;
    for (int n = 0; n < 200 && !seen; n++) begin
      @(negedge clk);
      if (bus.frame_start === 1'b1) seen = 1;
    end
    checks++;
    assert (seen) else begin
      errors++;
      $error("FAIL frame_start_timeout observed=0 expected=1");
    end
  endtask

  // Entered just after the evaluation edge; a wrap frame needs one more edge to reach div 0.
  task automatic body(input bit after_reset);
    slot_exp_t e;
    int sl, ph;
    e = '0;
    if (!after_reset) begin
      @(posedge clk); #1;
    end
    for (int i = 0; i < 48; i++) begin
      sl = i / 8;
      ph = i % 8;
      if (ph < 2) begin
        chk($sformatf("guard_sel s%0d p%0d", sl, ph), {2'b00, bus.SEL}, 8'h3F);
        chk($sformatf("guard_seg s%0d p%0d", sl, ph), bus.SEG, 8'hFF);
      end
      if (ph == 2) begin
        checks++;
        assert (exp_q.size() > 0) else begin
          errors++;
          $error("FAIL queue_empty slot=%0d observed=0 expected>0", sl);
        end
        if (exp_q.size() > 0) e = exp_q.pop_front();
      end
      if (ph == 2 || ph == 7) begin
        chk($sformatf("slot_seg s%0d p%0d", sl, ph), bus.SEG, e.seg);
        chk($sformatf("slot_sel s%0d p%0d", sl, ph), {2'b00, bus.SEL}, {2'b00, e.sel});
      end
      if (i < 47) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic check_frame();
    wait_fs();
    @(posedge clk); #1;
    body(1'b0);
  endtask

  initial begin
    seg_tbl[0] = 7'h40; seg_tbl[1] = 7'h79; seg_tbl[2] = 7'h24; seg_tbl[3] = 7'h30;
    seg_tbl[4] = 7'h19; seg_tbl[5] = 7'h12; seg_tbl[6] = 7'h02; seg_tbl[7] = 7'h78;
    seg_tbl[8] = 7'h00; seg_tbl[9] = 7'h10;
    sel_tbl[0] = 6'h3E; sel_tbl[1] = 6'h3D; sel_tbl[2] = 6'h3B;
    sel_tbl[3] = 6'h37; sel_tbl[4] = 6'h2F; sel_tbl[5] = 6'h1F;

    bus.blank_lz = 1'b0;
    bus.dot_en   = 1'b0;
    drive(1, 2, 0, 0, 0, 0);
    model_reset();

    // Initial reset, then let slot 0 light up.
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("lit_before_reset_seg", bus.SEG, 8'hC0);
    chk("lit_before_reset_sel", {2'b00, bus.SEL}, 8'h3E);

    // 1. Reset asserted mid-cycle goes dark without waiting for a clock.
    #2 rst = 1'b1;
    #1;
    chk("reset_sel", {2'b00, bus.SEL}, 8'h3F);
    chk("reset_seg", bus.SEG, 8'hFF);
    chk("reset_frame_start", {7'b0, bus.frame_start}, 8'h00);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    model_reset();
    model_apply(1, 2, 0, 0, 0, 0);
    push_expected();
    #1;
    chk("release_frame_start", {7'b0, bus.frame_start}, 8'h01);
    @(posedge clk); #1;
    body(1'b1);

    // 2. Normal frame.
    apply(1, 2, 3, 4, 5, 6);
    check_frame();

    // 3. Invalid digit present only in the wrap-tick cycle.
    wait_fs();
    bus.seconds1_data = 4'd10;
    model_apply(1, 2, 3, 4, 5, 10);
    push_expected();
    chk("glitch_frame_start", {7'b0, bus.frame_start}, 8'h01);
    @(posedge clk); #1;
    bus.seconds1_data = 4'd6;
    body(1'b0);

    // 4. Leading-zero blanking on and off.
    bus.blank_lz = 1'b1;
    apply(0, 9, 0, 0, 0, 0);
    check_frame();
    bus.blank_lz = 1'b0;
    push_expected();
    check_frame();

    // 5. Decimal points.
    bus.dot_en = 1'b1;
    apply(1, 2, 3, 4, 5, 6);
    check_frame();
    bus.dot_en = 1'b0;

    // 6. Out-of-range hour rejected, then midnight accepted.
    apply(2, 3, 5, 9, 5, 9);
    check_frame();
    apply(2, 4, 0, 0, 0, 0);
    check_frame();
    apply(0, 0, 0, 0, 0, 0);
    check_frame();

    chk("queue_drained", 8'(exp_q.size()), 8'h00);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
